score_manager: RTL and testbench
================================

# score_manager

Game-level controller that owns the player score and schedules what the two-digit 7-segment score encoder displays. It counts point pulses from the game logic, tracks a session high score, and sequences the display between current score, high score and a game-over blink. Its `o_Score` and `o_Display_On` outputs drive the score-to-segment encoder directly.

## Interface
Parameters:
- `MAX_SCORE`, default 99: saturation value. Legal range 1..99, which is the encoder's range.
- `BLINK_CYCLES`, default 12_500_000: number of clocks per blink half-period in OVER.
- `HIGH_SHOW_CYCLES`, default 50_000_000: number of clocks the high score stays displayed.

Ports:
- `i_Clk`, in, 1: system clock.
- `i_Reset`, in, 1: asynchronous, active-high reset.
- `i_Game_Start`, in, 1: single-cycle pulse that starts a new game.
- `i_Point`, in, 1: single-cycle pulse that adds one point.
- `i_Game_Over`, in, 1: single-cycle pulse that ends the game.
- `i_Show_High`, in, 1: single-cycle pulse, from a debounced button, that requests high-score display.
- `o_Score`, out, 7: binary value for the encoder, range 0..MAX_SCORE.
- `o_Display_On`, out, 1: 1 means the digits are lit; 0 means blank.
- `o_State`, out, 2: current state. IDLE=0, PLAY=1, OVER=2, HIGH=3.
- `o_High_Score`, out, 7: session high score.
- `o_New_High`, out, 1: set when the last game beat the previous high score.

## Operation
Reset values:
- State = IDLE.
- Internal score = 0, and `o_Score` = 0.
- `o_High_Score` = 0.
- `o_Display_On` = 1.
- `o_New_High` = 0.
- All counters = 0.

State behaviour:
- **IDLE**
  - Displays the internal score (0 after reset).
  - `i_Game_Start` → PLAY.
  - Otherwise `i_Show_High` → HIGH, with return state IDLE.
- **PLAY**
  - On entry: score cleared to 0 and `o_New_High` cleared.
  - `i_Point` increments the score, saturating at MAX_SCORE. A point pulse at MAX_SCORE holds the value.
  - `i_Game_Over` → OVER.
  - `i_Game_Start` and `i_Show_High` are ignored.
- **Point and game over in the same cycle:** the point is counted first. The high-score comparison uses the incremented value.
- **On the PLAY→OVER transition:** if the final score is strictly greater than `o_High_Score`, then `o_High_Score` takes the final score and `o_New_High` = 1. A tie leaves both unchanged.
- **OVER**
  - Displays the final score and blinks (see Configuration).
  - `i_Game_Start` → PLAY.
  - Otherwise `i_Show_High` → HIGH, with return state OVER.
  - `i_Point` and `i_Game_Over` are ignored.
- **HIGH**
  - `o_Score` = `o_High_Score` and `o_Display_On` = 1.
  - A dwell counter runs for HIGH_SHOW_CYCLES clocks, then the block returns to the saved return state.
  - `i_Game_Start` → PLAY immediately.
  - A repeated `i_Show_High` restarts the dwell counter.
  - On return to OVER, the blink restarts from the lit phase.
- **Priority within a cycle:** `i_Game_Start` > `i_Game_Over` > `i_Show_High`. `i_Point` is independent of these and only has effect in PLAY.
- **Internal score:** never reset by HIGH or OVER. It is only cleared on PLAY entry or by reset.

## Timing
- All outputs are registered.
- `o_Score` reflects an `i_Point` pulse on the clock edge after the pulse is sampled (1-cycle latency).
- State transitions take effect on the edge that samples the pulse:
  - `o_State` changes in that same update.
  - `o_Score` shows 0 from the first PLAY cycle.
- `o_High_Score` and `o_New_High` update on the same edge on which `o_State` becomes OVER.
- HIGH lasts exactly HIGH_SHOW_CYCLES cycles measured in `o_State`, unless it is interrupted.
- Blink: `o_Display_On` = 1 for the first BLINK_CYCLES cycles in OVER, then toggles every BLINK_CYCLES cycles.
- Reset asserted mid-game: all outputs return to their reset values asynchronously. The high score is lost.
- Input pulses present while `i_Reset` is high are discarded.

## Configuration
- `SCORE_BLINK_EN` defined:
  - OVER blinks as described in Timing.
  - The blink counter is compiled in.
- `SCORE_BLINK_EN` undefined:
  - `o_Display_On` is constant 1 in every state.
  - No blink counter is built.
  - All other behaviour is identical.

## Test plan
The bench uses MAX_SCORE=99, BLINK_CYCLES=4 and HIGH_SHOW_CYCLES=8.
- **Reset then 12 points:** reset, `i_Game_Start`, then 12 `i_Point` pulses → `o_Score`=12 one cycle after the last pulse, and `o_State`=1.
- **Saturation and high score:** 105 points in PLAY → `o_Score` stays 99. Then `i_Game_Over` → `o_State`=2, `o_High_Score`=99, `o_New_High`=1.
- **Same-cycle point and game over:** score 41 with high 41, then `i_Point` and `i_Game_Over` in the same cycle → final score 42, `o_High_Score`=42, `o_New_High`=1. A replay ending at a tie of 42 → `o_New_High`=0.
- **Show high from OVER:** final score 7 with high 30, then `i_Show_High` in OVER → `o_Score`=30 for exactly 8 cycles, then `o_Score`=7 with OVER resumed and `o_Display_On`=1.
- **Blink:** with `SCORE_BLINK_EN` defined, `o_Display_On` reads 1,1,1,1,0,0,0,0,1… after entering OVER. With it undefined, `o_Display_On` stays at 1.
- **Reset mid-game:** `i_Reset` pulsed at score 25 in PLAY → all outputs return to their reset values without waiting for a clock edge. A subsequent `i_Point` without `i_Game_Start` leaves `o_Score`=0.

Source files
------------

// File: rtl/score_manager.sv
// -----------------------------------------------------------------------------
// score_manager
//
// Game-level controller that owns the player score, tracks the session high
// score and sequences what the two-digit 7-segment encoder shows: current
// score, high score, or a blinking final score after game over.
//
// Optional feature macro: SCORE_BLINK_EN
//   defined   -> o_Display_On blinks while in OVER (blink counter built)
//   undefined -> o_Display_On is constant 1, no blink counter
//
// Ports:
//   i_Clk          system clock
//   i_Reset        asynchronous active-high reset
//   i_Game_Start   1-cycle pulse, start a new game
//   i_Point        1-cycle pulse, add one point (PLAY only)
//   i_Game_Over    1-cycle pulse, end the game (PLAY only)
//   i_Show_High    1-cycle pulse, show high score (IDLE/OVER/HIGH)
//   o_Score        value for the encoder, 0..MAX_SCORE
//   o_Display_On   1 = digits lit, 0 = blank
//   o_State        IDLE=0, PLAY=1, OVER=2, HIGH=3
//   o_High_Score   session high score
//   o_New_High     last game beat the previous high score
//
// Handshake: all inputs are single-cycle pulses with no back-pressure; a
// pulse is consumed on the rising edge that samples it. All outputs are
// registered.
// -----------------------------------------------------------------------------
module score_manager #(
    parameter int MAX_SCORE        = 99,
    parameter int BLINK_CYCLES     = 12_500_000,
    parameter int HIGH_SHOW_CYCLES = 50_000_000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Game_Start,
    input  logic       i_Point,
    input  logic       i_Game_Over,
    input  logic       i_Show_High,
    output logic [6:0] o_Score,
    output logic       o_Display_On,
    output logic [1:0] o_State,
    output logic [6:0] o_High_Score,
    output logic       o_New_High
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2,
        S_HIGH = 2'd3
    } state_t;

    localparam int DWELL_W = (HIGH_SHOW_CYCLES > 1) ? $clog2(HIGH_SHOW_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HIGH_SHOW_CYCLES - 1);
    localparam logic [6:0] MAX_VAL = 7'(MAX_SCORE);

    state_t             r_state, w_state_next;
    state_t             r_ret_state, w_ret_next;
    logic [6:0]         r_score, w_score_next;
    logic [6:0]         r_high, w_high_next;
    logic               r_new_high, w_new_high_next;
    logic [DWELL_W-1:0] r_dwell, w_dwell_next;
    logic [6:0]         r_out_score, w_out_score_next;
    logic [6:0]         w_score_inc;

    // Saturating increment; used for both the score update and the high-score
    // comparison so a point arriving with game over is counted first.
    assign w_score_inc = (i_Point && (r_score < MAX_VAL)) ? r_score + 7'd1 : r_score;

    always_comb begin
        w_state_next    = r_state;
        w_ret_next      = r_ret_state;
        w_score_next    = r_score;
        w_high_next     = r_high;
        w_new_high_next = r_new_high;
        w_dwell_next    = '0;
        case (r_state)
            S_IDLE: begin
                if (i_Game_Start) begin
                    w_state_next    = S_PLAY;
                    w_score_next    = 7'd0;
                    w_new_high_next = 1'b0;
                end else if (i_Show_High) begin
                    w_state_next = S_HIGH;
                    w_ret_next   = S_IDLE;
                end
            end
            S_PLAY: begin
                w_score_next = w_score_inc;
                if (i_Game_Over) begin
                    w_state_next = S_OVER;
                    if (w_score_inc > r_high) begin
                        w_high_next     = w_score_inc;
                        w_new_high_next = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (i_Game_Start) begin
                    w_state_next    = S_PLAY;
                    w_score_next    = 7'd0;
                    w_new_high_next = 1'b0;
                end else if (i_Show_High) begin
                    w_state_next = S_HIGH;
                    w_ret_next   = S_OVER;
                end
            end
            S_HIGH: begin
                if (i_Game_Start) begin
                    w_state_next    = S_PLAY;
                    w_score_next    = 7'd0;
                    w_new_high_next = 1'b0;
                end else if (i_Show_High) begin
                    w_dwell_next = '0;          // restart the dwell window
                end else if (r_dwell == DWELL_LAST) begin
                    w_state_next = r_ret_state;
                end else begin
                    w_dwell_next = r_dwell + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output score is registered from next-state values so it tracks o_State
    // on the same edge.
    assign w_out_score_next = (w_state_next == S_HIGH) ? w_high_next : w_score_next;

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state     <= S_IDLE;
            r_ret_state <= S_IDLE;
            r_score     <= 7'd0;
            r_high      <= 7'd0;
            r_new_high  <= 1'b0;
            r_dwell     <= '0;
            r_out_score <= 7'd0;
        end else begin
            r_state     <= w_state_next;
            r_ret_state <= w_ret_next;
            r_score     <= w_score_next;
            r_high      <= w_high_next;
            r_new_high  <= w_new_high_next;
            r_dwell     <= w_dwell_next;
            r_out_score <= w_out_score_next;
        end
    end

`ifdef SCORE_BLINK_EN
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic               r_display, w_display_next;

    // Any entry into OVER (from PLAY or back from HIGH) starts lit with a
    // fresh half-period; outside OVER the digits are always lit.
    always_comb begin
        w_blink_cnt_next = '0;
        w_display_next   = 1'b1;
        if ((w_state_next == S_OVER) && (r_state == S_OVER)) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_next = '0;
                w_display_next   = ~r_display;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 1'b1;
                w_display_next   = r_display;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_blink_cnt <= '0;
            r_display   <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_next;
            r_display   <= w_display_next;
        end
    end

    assign o_Display_On = r_display;
`else
    assign o_Display_On = 1'b1;
`endif

    assign o_Score      = r_out_score;
    assign o_State      = r_state;
    assign o_High_Score = r_high;
    assign o_New_High   = r_new_high;

endmodule

// File: tb/tb_score_manager.sv
module tb_score_manager;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Game_Start = 1'b0;
    logic       i_Point = 1'b0;
    logic       i_Game_Over = 1'b0;
    logic       i_Show_High = 1'b0;
    logic [6:0] o_Score;
    logic       o_Display_On;
    logic [1:0] o_State;
    logic [6:0] o_High_Score;
    logic       o_New_High;

    int checks = 0;
    int failures = 0;

    score_manager #(
        .MAX_SCORE(99),
        .BLINK_CYCLES(4),
        .HIGH_SHOW_CYCLES(8)
    ) dut (
        .i_Clk(i_Clk),
        .i_Reset(i_Reset),
        .i_Game_Start(i_Game_Start),
        .i_Point(i_Point),
        .i_Game_Over(i_Game_Over),
        .i_Show_High(i_Show_High),
        .o_Score(o_Score),
        .o_Display_On(o_Display_On),
        .o_State(o_State),
        .o_High_Score(o_High_Score),
        .o_New_High(o_New_High)
    );

    always #5 i_Clk = ~i_Clk;

    // Inputs change on the falling edge; outputs are read on the next falling
    // edge, after the rising edge has consumed the pulse.
    task automatic do_reset();
        @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
    endtask

    task automatic pulse_start();
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        i_Game_Start = 1'b0;
    endtask

    task automatic pulse_over();
        i_Game_Over = 1'b1;
        @(negedge i_Clk);
        i_Game_Over = 1'b0;
    endtask

    task automatic pulse_show();
        i_Show_High = 1'b1;
        @(negedge i_Clk);
        i_Show_High = 1'b0;
    endtask

    task automatic points(input int n);
        for (int i = 0; i < n; i++) begin
            i_Point = 1'b1;
            @(negedge i_Clk);
            i_Point = 1'b0;
        end
    endtask

    // Plays one complete game ending with the given score.
    task automatic play_game(input int n);
        pulse_start();
        points(n);
        pulse_over();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (o_State !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_State); end
        checks++; if (o_Score !== 7'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", o_Score); end
        checks++; if (o_High_Score !== 7'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", o_High_Score); end
        checks++; if (o_Display_On !== 1'b1) begin failures++; $display("FAIL reset_disp got=%0b exp=1", o_Display_On); end
        checks++; if (o_New_High !== 1'b0) begin failures++; $display("FAIL reset_newhigh got=%0b exp=0", o_New_High); end
        @(negedge i_Clk);
        i_Reset = 1'b0;
    endtask

    task automatic test_points();
        pulse_start();
        checks++; if (o_State !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", o_State); end
        checks++; if (o_Score !== 7'd0) begin failures++; $display("FAIL start_score got=%0d exp=0", o_Score); end
        points(12);
        checks++; if (o_Score !== 7'd12) begin failures++; $display("FAIL pts12_score got=%0d exp=12", o_Score); end
        checks++; if (o_State !== 2'd1) begin failures++; $display("FAIL pts12_state got=%0d exp=1", o_State); end
        // start and show-high are ignored during play
        pulse_show();
        checks++; if (o_State !== 2'd1 || o_Score !== 7'd12) begin failures++; $display("FAIL play_ignore state=%0d score=%0d exp=1/12", o_State, o_Score); end
    endtask

    task automatic test_saturation();
        do_reset();
        pulse_start();
        points(105);
        checks++; if (o_Score !== 7'd99) begin failures++; $display("FAIL sat_score got=%0d exp=99", o_Score); end
        pulse_over();
        checks++; if (o_State !== 2'd2) begin failures++; $display("FAIL sat_over_state got=%0d exp=2", o_State); end
        checks++; if (o_High_Score !== 7'd99) begin failures++; $display("FAIL sat_high got=%0d exp=99", o_High_Score); end
        checks++; if (o_New_High !== 1'b1) begin failures++; $display("FAIL sat_newhigh got=%0b exp=1", o_New_High); end
        checks++; if (o_Score !== 7'd99) begin failures++; $display("FAIL sat_final got=%0d exp=99", o_Score); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        play_game(41);
        checks++; if (o_High_Score !== 7'd41) begin failures++; $display("FAIL sc_high41 got=%0d exp=41", o_High_Score); end
        pulse_start();
        checks++; if (o_New_High !== 1'b0) begin failures++; $display("FAIL sc_newhigh_clr got=%0b exp=0", o_New_High); end
        points(41);
        i_Point = 1'b1;
        i_Game_Over = 1'b1;
        @(negedge i_Clk);
        i_Point = 1'b0;
        i_Game_Over = 1'b0;
        checks++; if (o_Score !== 7'd42) begin failures++; $display("FAIL sc_score got=%0d exp=42", o_Score); end
        checks++; if (o_High_Score !== 7'd42) begin failures++; $display("FAIL sc_high got=%0d exp=42", o_High_Score); end
        checks++; if (o_New_High !== 1'b1) begin failures++; $display("FAIL sc_newhigh got=%0b exp=1", o_New_High); end
        // points after game over are ignored
        points(3);
        checks++; if (o_Score !== 7'd42 || o_State !== 2'd2) begin failures++; $display("FAIL over_ignore score=%0d state=%0d exp=42/2", o_Score, o_State); end
        play_game(42);
        checks++; if (o_New_High !== 1'b0) begin failures++; $display("FAIL tie_newhigh got=%0b exp=0", o_New_High); end
        checks++; if (o_High_Score !== 7'd42) begin failures++; $display("FAIL tie_high got=%0d exp=42", o_High_Score); end
    endtask

    // Reads o_Display_On for n consecutive cycles starting 'phase' cycles
    // into an OVER stretch and compares with the expected blink pattern.
    task automatic check_blink(input string name, input int phase, input int n);
        logic exp_d;
        for (int k = 0; k < n; k++) begin
`ifdef SCORE_BLINK_EN
            exp_d = (((phase + k) / 4) % 2 == 0) ? 1'b1 : 1'b0;
`else
            exp_d = 1'b1;
`endif
            checks++;
            if (o_Display_On !== exp_d || o_State !== 2'd2) begin
                failures++;
                $display("FAIL %s[%0d] disp=%0b state=%0d exp=%0b/2", name, k, o_Display_On, o_State, exp_d);
            end
            @(negedge i_Clk);
        end
    endtask

    task automatic test_show_high_over();
        int cnt;
        do_reset();
        play_game(30);
        play_game(7);
        checks++; if (o_Score !== 7'd7 || o_High_Score !== 7'd30) begin failures++; $display("FAIL sh_setup score=%0d high=%0d exp=7/30", o_Score, o_High_Score); end
        check_blink("blink", 0, 9);
        // now 9 cycles into OVER (display lit again when blinking)
        pulse_show();
        cnt = 0;
        while (o_State == 2'd3 && cnt < 20) begin
            cnt++;
            checks++; if (o_Score !== 7'd30 || o_Display_On !== 1'b1) begin failures++; $display("FAIL sh_high score=%0d disp=%0b exp=30/1", o_Score, o_Display_On); end
            @(negedge i_Clk);
        end
        checks++; if (cnt !== 8) begin failures++; $display("FAIL sh_dwell got=%0d exp=8", cnt); end
        checks++; if (o_State !== 2'd2 || o_Score !== 7'd7) begin failures++; $display("FAIL sh_return state=%0d score=%0d exp=2/7", o_State, o_Score); end
        check_blink("reblink", 0, 6);
    endtask

    task automatic test_high_restart();
        int cnt;
        do_reset();
        pulse_show();
        checks++; if (o_State !== 2'd3 || o_Score !== 7'd0) begin failures++; $display("FAIL hr_enter state=%0d score=%0d exp=3/0", o_State, o_Score); end
        @(negedge i_Clk);
        @(negedge i_Clk);
        pulse_show();
        cnt = 0;
        while (o_State == 2'd3 && cnt < 20) begin
            cnt++;
            @(negedge i_Clk);
        end
        checks++; if (cnt !== 8) begin failures++; $display("FAIL hr_dwell got=%0d exp=8", cnt); end
        checks++; if (o_State !== 2'd0) begin failures++; $display("FAIL hr_return got=%0d exp=0", o_State); end
        // game start interrupts HIGH at once
        pulse_show();
        @(negedge i_Clk);
        pulse_start();
        checks++; if (o_State !== 2'd1 || o_Score !== 7'd0) begin failures++; $display("FAIL hr_start state=%0d score=%0d exp=1/0", o_State, o_Score); end
    endtask

    task automatic test_reset_mid_game();
        do_reset();
        play_game(10);
        pulse_start();
        points(25);
        checks++; if (o_Score !== 7'd25) begin failures++; $display("FAIL rm_score25 got=%0d exp=25", o_Score); end
        #2;
        i_Reset = 1'b1;
        #1;
        checks++; if (o_State !== 2'd0) begin failures++; $display("FAIL rm_state got=%0d exp=0", o_State); end
        checks++; if (o_Score !== 7'd0) begin failures++; $display("FAIL rm_score got=%0d exp=0", o_Score); end
        checks++; if (o_High_Score !== 7'd0) begin failures++; $display("FAIL rm_high got=%0d exp=0", o_High_Score); end
        checks++; if (o_Display_On !== 1'b1 || o_New_High !== 1'b0) begin failures++; $display("FAIL rm_flags disp=%0b newhigh=%0b exp=1/0", o_Display_On, o_New_High); end
        @(negedge i_Clk);
        i_Reset = 1'b0;
        points(1);
        checks++; if (o_Score !== 7'd0 || o_State !== 2'd0) begin failures++; $display("FAIL rm_point score=%0d state=%0d exp=0/0", o_Score, o_State); end
    endtask

    initial begin
        test_reset();
        test_points();
        test_saturation();
        test_same_cycle();
        test_show_high_over();
        test_high_restart();
        test_reset_mid_game();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
